// File: rtl/clint_ipi_seq_if.sv
// Command/completion and register-bus interfaces for the CLINT IPI sequencer.
interface clint_ipi_cmd_if #(
  parameter int unsigned NrHarts = 5
);
  logic               cmd_valid_i;
  logic               cmd_ready_o;
  logic [NrHarts-1:0] cmd_mask_i;
  logic               cmd_set_i;
  logic               done_valid_o;
  logic               done_err_o;
  logic [NrHarts-1:0] done_errmask_o;

  modport master (
    output cmd_valid_i, cmd_mask_i, cmd_set_i,
    input  cmd_ready_o, done_valid_o, done_err_o, done_errmask_o
  );
  modport slave (
    input  cmd_valid_i, cmd_mask_i, cmd_set_i,
    output cmd_ready_o, done_valid_o, done_err_o, done_errmask_o
  );
endinterface

interface clint_ipi_reg_if;
  logic        reg_valid_o;
  logic [31:0] reg_addr_o;
  logic        reg_write_o;
  logic [31:0] reg_wdata_o;
  logic [3:0]  reg_wstrb_o;
  logic        reg_ready_i;
  logic        reg_error_i;

  modport master (
    output reg_valid_o, reg_addr_o, reg_write_o, reg_wdata_o, reg_wstrb_o,
    input  reg_ready_i, reg_error_i
  );
  modport slave (
    input  reg_valid_o, reg_addr_o, reg_write_o, reg_wdata_o, reg_wstrb_o,
    output reg_ready_i, reg_error_i
  );
endinterface

// File: rtl/clint_ipi_seq.sv
// CLINT IPI sequencer: turns one raise/clear command into per-hart msip writes,
// issued in ascending hart order, and reports a per-hart error mask.
module clint_ipi_seq #(
  parameter int unsigned NrHarts       = 5,
  parameter logic [31:0] MsipBase      = 32'h0000_0000,
  parameter int unsigned TimeoutCycles = 16
) (
  input  logic            clk_i,
  input  logic            rst_i,
  clint_ipi_cmd_if.slave  cmd,
  clint_ipi_reg_if.master bus,
  output logic            busy_o
);

  localparam int unsigned IdxW = (NrHarts > 1) ? $clog2(NrHarts) : 1;
  localparam int unsigned TcW  = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;
  localparam logic [TcW-1:0] TcLast = TcW'((TimeoutCycles > 0) ? TimeoutCycles - 1 : 0);

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_DONE} state_t;

  state_t             r_state, w_state_nxt;
  logic [NrHarts-1:0] r_pending, w_pending_nxt;
  logic [NrHarts-1:0] r_errmask, w_errmask_nxt;
  logic               r_set, w_set_nxt;
  logic [TcW-1:0]     r_tcnt, w_tcnt_nxt;
  logic [NrHarts-1:0] w_onehot;
  logic [NrHarts-1:0] w_remaining;
  logic [IdxW-1:0]    w_idx;
  logic               w_timeout;
  logic               w_finish;

  // Lowest pending hart, both as a one-hot bit and as an index.
  assign w_onehot    = r_pending & (~r_pending + NrHarts'(1));
  assign w_remaining = r_pending & ~w_onehot;

  always_comb begin
    w_idx = '0;
    for (int i = NrHarts - 1; i >= 0; i--) begin
      if (r_pending[i]) w_idx = IdxW'(i);
    end
  end

  assign w_timeout = (TimeoutCycles != 0) && (r_tcnt == TcLast) && !bus.reg_ready_i;
  assign w_finish  = bus.reg_ready_i || w_timeout;

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_pending <= '0;
      r_errmask <= '0;
      r_set     <= 1'b0;
      r_tcnt    <= '0;
    end else begin
      r_pending <= w_pending_nxt;
      r_errmask <= w_errmask_nxt;
      r_set     <= w_set_nxt;
      r_tcnt    <= w_tcnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt        = r_state;
    w_pending_nxt      = r_pending;
    w_errmask_nxt      = r_errmask;
    w_set_nxt          = r_set;
    w_tcnt_nxt         = r_tcnt;
    busy_o             = 1'b1;
    cmd.cmd_ready_o    = 1'b0;
    cmd.done_valid_o   = 1'b0;
    cmd.done_err_o     = 1'b0;
    cmd.done_errmask_o = '0;
    bus.reg_valid_o    = 1'b0;
    bus.reg_write_o    = 1'b0;
    bus.reg_addr_o     = MsipBase + (32'(w_idx) << 2);
    bus.reg_wdata_o    = '0;
    bus.reg_wstrb_o    = '0;

    case (r_state)
      S_IDLE: begin
        busy_o          = 1'b0;
        cmd.cmd_ready_o = 1'b1;
        if (cmd.cmd_valid_i) begin
          w_pending_nxt = cmd.cmd_mask_i;
          w_set_nxt     = cmd.cmd_set_i;
          w_errmask_nxt = '0;
          w_tcnt_nxt    = '0;
          w_state_nxt   = (|cmd.cmd_mask_i) ? S_WRITE : S_DONE;
        end
      end
      S_WRITE: begin
        bus.reg_valid_o = 1'b1;
        bus.reg_write_o = 1'b1;
        bus.reg_wdata_o = {31'b0, r_set};
        bus.reg_wstrb_o = 4'hF;
        // A completing handshake takes precedence over a coincident timeout.
        if (bus.reg_ready_i) begin
          w_pending_nxt = w_remaining;
          w_errmask_nxt = r_errmask | (bus.reg_error_i ? w_onehot : '0);
          w_tcnt_nxt    = '0;
        end else if (w_timeout) begin
          w_pending_nxt = w_remaining;
          w_errmask_nxt = r_errmask | w_onehot;
          w_tcnt_nxt    = '0;
        end else if (TimeoutCycles != 0) begin
          w_tcnt_nxt = r_tcnt + TcW'(1);
        end
        if (w_finish && (w_remaining == '0)) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        cmd.done_valid_o   = 1'b1;
        cmd.done_errmask_o = r_errmask;
        cmd.done_err_o     = |r_errmask;
        w_state_nxt        = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_clint_ipi_seq.sv
// Directed bench for clint_ipi_seq with a write/completion scoreboard.
module tb_clint_ipi_seq;

  localparam int unsigned NH = 5;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy;

  clint_ipi_cmd_if #(.NrHarts(NH)) cmd_if ();
  clint_ipi_reg_if                 reg_if ();

  clint_ipi_seq #(
    .NrHarts      (NH),
    .MsipBase     (32'h0000_0000),
    .TimeoutCycles(16)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .cmd   (cmd_if),
    .bus   (reg_if),
    .busy_o(busy)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  int done_cnt = 0;

  wr_t             exp_wr[$];
  logic [NH-1:0]   exp_done[$];

  // Bus responder: ready after stall_n wait cycles, error on one address.
  int          stall_n  = 0;
  bit          resp_en  = 1'b1;
  bit          err_en   = 1'b0;
  logic [31:0] err_addr = 32'h0;
  logic [7:0]  wait_cnt = 8'd0;

  assign reg_if.reg_ready_i = resp_en && reg_if.reg_valid_o && (int'(wait_cnt) >= stall_n);
  assign reg_if.reg_error_i = err_en && reg_if.reg_valid_o && (reg_if.reg_addr_o == err_addr);

  always @(posedge clk) begin
    if (reg_if.reg_valid_o && !reg_if.reg_ready_i) wait_cnt <= wait_cnt + 8'd1;
    else                                           wait_cnt <= 8'd0;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor: completed writes and done pulses.
  always @(negedge clk) begin
    if (reg_if.reg_valid_o && reg_if.reg_ready_i) begin
      check("wr_expected", 32'(exp_wr.size() != 0), 32'd1);
      if (exp_wr.size() != 0) begin
        wr_t e;
        e = exp_wr.pop_front();
        check("wr_addr",  reg_if.reg_addr_o, e.addr);
        check("wr_wdata", reg_if.reg_wdata_o, e.wdata);
        check("wr_write", 32'(reg_if.reg_write_o), 32'd1);
        check("wr_wstrb", 32'(reg_if.reg_wstrb_o), 32'hF);
      end
    end
    if (cmd_if.done_valid_o) begin
      done_cnt++;
      check("done_expected", 32'(exp_done.size() != 0), 32'd1);
      if (exp_done.size() != 0) begin
        logic [NH-1:0] m;
        m = exp_done.pop_front();
        check("done_errmask", 32'(cmd_if.done_errmask_o), 32'(m));
        check("done_err",     32'(cmd_if.done_err_o), 32'(|m));
      end
    end
  end

  task automatic push_writes(input logic [NH-1:0] mask, input logic set);
    for (int i = 0; i < int'(NH); i++) begin
      if (mask[i]) begin
        wr_t e;
        e.addr  = 32'(i) << 2;
        e.wdata = {31'b0, set};
        exp_wr.push_back(e);
      end
    end
  endtask

  task automatic run_cmd(input logic [NH-1:0] mask, input logic set,
                         input logic [NH-1:0] exp_err, input bit completes,
                         output int done_cyc, output int vcnt);
    if (completes) push_writes(mask, set);
    exp_done.push_back(exp_err);
    @(posedge clk); #1;
    cmd_if.cmd_valid_i = 1'b1;
    cmd_if.cmd_mask_i  = mask;
    cmd_if.cmd_set_i   = set;
    @(negedge clk);
    check("cmd_ready_c0", 32'(cmd_if.cmd_ready_o), 32'd1);
    @(posedge clk); #1;
    cmd_if.cmd_valid_i = 1'b0;
    done_cyc = 0;
    vcnt     = 0;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      if (reg_if.reg_valid_o) vcnt++;
      if (cmd_if.done_valid_o) begin
        done_cyc = c;
        break;
      end
    end
    check("done_seen", 32'(done_cyc != 0), 32'd1);
    @(negedge clk);
    check("done_one_cycle", 32'(cmd_if.done_valid_o), 32'd0);
    check("cmd_ready_after", 32'(cmd_if.cmd_ready_o), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int dc, vc, early, found, dcnt0;
    cmd_if.cmd_valid_i = 1'b0;
    cmd_if.cmd_mask_i  = '0;
    cmd_if.cmd_set_i   = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_cmd_ready", 32'(cmd_if.cmd_ready_o), 32'd1);
    check("rst_reg_valid", 32'(reg_if.reg_valid_o), 32'd0);
    check("rst_done",      32'(cmd_if.done_valid_o), 32'd0);
    check("rst_busy",      32'(busy), 32'd0);
    check("rst_errmask",   32'(cmd_if.done_errmask_o), 32'd0);
    check("rst_addr",      reg_if.reg_addr_o, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    // All harts of mask 10101, no stall
    run_cmd(5'b10101, 1'b1, 5'b00000, 1'b1, dc, vc);
    check("t1_done_cycle", 32'(dc), 32'd4);
    check("t1_valid_cycles", 32'(vc), 32'd3);

    // Stalled bus: 3 wait cycles per write
    stall_n = 3;
    run_cmd(5'b00011, 1'b0, 5'b00000, 1'b1, dc, vc);
    check("t2_done_cycle", 32'(dc), 32'd9);
    check("t2_valid_cycles", 32'(vc), 32'd8);
    stall_n = 0;

    // Timeout: ready never comes
    resp_en = 1'b0;
    run_cmd(5'b00100, 1'b1, 5'b00100, 1'b0, dc, vc);
    check("t3_valid_cycles", 32'(vc), 32'd16);
    check("t3_done_cycle", 32'(dc), 32'd17);
    resp_en = 1'b1;

    // Bus error on hart 3 only
    err_en   = 1'b1;
    err_addr = 32'hC;
    run_cmd(5'b11111, 1'b1, 5'b01000, 1'b1, dc, vc);
    check("t4_done_cycle", 32'(dc), 32'd6);
    check("t4_valid_cycles", 32'(vc), 32'd5);
    err_en = 1'b0;

    // Empty mask
    run_cmd(5'b00000, 1'b1, 5'b00000, 1'b1, dc, vc);
    check("t5_done_cycle", 32'(dc), 32'd1);
    check("t5_valid_cycles", 32'(vc), 32'd0);

    // New command held during WRITE is not accepted before DONE completes
    stall_n = 2;
    push_writes(5'b00011, 1'b1);
    push_writes(5'b10000, 1'b0);
    exp_done.push_back(5'b00000);
    exp_done.push_back(5'b00000);
    @(posedge clk); #1;
    cmd_if.cmd_valid_i = 1'b1;
    cmd_if.cmd_mask_i  = 5'b00011;
    cmd_if.cmd_set_i   = 1'b1;
    @(negedge clk);
    check("t6_ready_c0", 32'(cmd_if.cmd_ready_o), 32'd1);
    @(posedge clk); #1;
    cmd_if.cmd_mask_i = 5'b10000;
    cmd_if.cmd_set_i  = 1'b0;
    early = 0;
    found = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (cmd_if.cmd_ready_o) early++;
      if (cmd_if.done_valid_o) begin
        found = 1;
        break;
      end
    end
    check("t6_first_done", 32'(found), 32'd1);
    check("t6_no_early_accept", 32'(early), 32'd0);
    @(negedge clk);
    check("t6_ready_after_done", 32'(cmd_if.cmd_ready_o), 32'd1);
    @(posedge clk); #1;
    cmd_if.cmd_valid_i = 1'b0;
    found = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (cmd_if.done_valid_o) begin
        found = 1;
        break;
      end
    end
    check("t6_second_done", 32'(found), 32'd1);

    // Reset during the second write of mask 00111
    stall_n = 5;
    push_writes(5'b00001, 1'b1);
    @(posedge clk); #1;
    cmd_if.cmd_valid_i = 1'b1;
    cmd_if.cmd_mask_i  = 5'b00111;
    cmd_if.cmd_set_i   = 1'b1;
    @(posedge clk); #1;
    cmd_if.cmd_valid_i = 1'b0;
    found = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (reg_if.reg_valid_o && reg_if.reg_addr_o == 32'h4) begin
        found = 1;
        break;
      end
    end
    check("t7_second_write_seen", 32'(found), 32'd1);
    dcnt0 = done_cnt;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("t7_rst_valid", 32'(reg_if.reg_valid_o), 32'd0);
    check("t7_rst_busy",  32'(busy), 32'd0);
    check("t7_rst_ready", 32'(cmd_if.cmd_ready_o), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    stall_n = 0;
    repeat (5) @(negedge clk);
    check("t7_no_done", 32'(done_cnt - dcnt0), 32'd0);
    check("t7_idle_ready", 32'(cmd_if.cmd_ready_o), 32'd1);
    check("t7_idle_valid", 32'(reg_if.reg_valid_o), 32'd0);

    // Scoreboard fully drained
    check("sb_writes_left", 32'(exp_wr.size()), 32'd0);
    check("sb_done_left",   32'(exp_done.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/clint_ipi_seq.md
# clint_ipi_seq

Inter-processor-interrupt sequencer for the CLINT. Accepts one command per transaction ("raise" or "clear" software interrupts for a set of harts) and converts it into a series of single-word writes to the CLINT `msip` registers over the register bus. Writes are issued one hart at a time, in ascending hart index. The block sits between a host-side IPI requester (boot/management logic or a mailbox) and the CLINT register port, and reports completion with a per-hart error mask.

## Interface

Parameters:
- `NrHarts`, default 5: number of harts and `msip` registers.
- `MsipBase`, default 32'h0000_0000: byte address of `msip[0]`. `msip[i]` is at `MsipBase + 4*i`.
- `TimeoutCycles`, default 16: maximum cycles a write may wait for `reg_ready_i`. 0 disables the timeout.

Ports:
- `clk_i` in 1: clock, the only clock.
- `rst_i` in 1: reset, synchronous, active-high.
- `cmd_valid_i` in 1: command valid.
- `cmd_ready_o` out 1: command accepted when valid and ready are both high.
- `cmd_mask_i` in NrHarts: harts to target.
- `cmd_set_i` in 1: 1 writes `msip=1`, 0 writes `msip=0`.
- `done_valid_o` out 1: one-cycle completion pulse.
- `done_err_o` out 1: OR of `done_errmask_o`.
- `done_errmask_o` out NrHarts: harts whose write returned an error or timed out.
- `busy_o` out 1: high in every state other than IDLE.
- `reg_valid_o` out 1: register request valid.
- `reg_addr_o` out 32: request byte address.
- `reg_write_o` out 1: always 1 while `reg_valid_o` is high.
- `reg_wdata_o` out 32: `{31'b0, set}`.
- `reg_wstrb_o` out 4: 4'hF.
- `reg_ready_i` in 1: request completes this cycle.
- `reg_error_i` in 1: error flag, sampled together with `reg_ready_i`.

## Operation

- **State registers:** the FSM state, `pending[NrHarts]`, `set_q`, `errmask[NrHarts]` and the timeout counter `tcnt`.
- **IDLE:** `cmd_ready_o=1`.
  - On handshake: `pending <= cmd_mask_i`, `set_q <= cmd_set_i`, `errmask <= 0`, `tcnt <= 0`.
  - Next state is WRITE if the mask is nonzero, otherwise DONE.
- **WRITE:**
  - `idx` = lowest set bit of `pending` (combinational priority encoder).
  - Drive `reg_valid_o=1`, `reg_addr_o = MsipBase + 4*idx`, `reg_wdata_o = {31'b0, set_q}`.
  - Request fields stay stable until the request completes or times out.
  - On `reg_ready_i`:
    - clear `pending[idx]`;
    - `errmask[idx] <= reg_error_i`;
    - `tcnt <= 0`.
  - Otherwise, when `TimeoutCycles != 0`, `tcnt` increments. Once `tcnt == TimeoutCycles-1` and ready is still low, that cycle counts as a timeout:
    - clear `pending[idx]`;
    - set `errmask[idx]`;
    - `tcnt <= 0`;
    - `reg_valid_o` is dropped for that hart.
  - If `reg_ready_i` and the timeout fire in the same cycle, ready wins and the error comes from `reg_error_i` only.
  - When the bit just cleared was the last one in `pending`, next state is DONE. Otherwise the FSM stays in WRITE and the next hart's request is presented in the following cycle (back-to-back, `reg_valid_o` stays high).
- **DONE:**
  - `done_valid_o=1` for exactly one cycle, with `done_errmask_o = errmask` and `done_err_o = |errmask`.
  - `cmd_ready_o=0`.
  - Next state is IDLE.
- `done_errmask_o` and `done_err_o` are driven as 0 whenever `done_valid_o` is 0.
- Commands are not queued. `cmd_ready_o` is low in WRITE and DONE.
- **Arithmetic:**
  - Address computed as 32-bit `MsipBase + (idx << 2)`; wraps modulo 2^32.
  - `tcnt` width is `$clog2(TimeoutCycles+1)`, minimum 1 bit.

## Timing

- **Reset values:**
  - state IDLE; `pending`, `errmask` and `tcnt` all 0;
  - `cmd_ready_o=1` from the first cycle after reset;
  - all other outputs 0 (`reg_addr_o` = `MsipBase`, `reg_wdata_o` = 0 are don't-care while `reg_valid_o` is low).
- **Latency:** command accepted in cycle 0.
  - First `reg_valid_o` in cycle 1.
  - With `reg_ready_i` tied high and k harts selected, writes occur in cycles 1..k, `done_valid_o` in cycle k+1, `cmd_ready_o` high again in cycle k+2.
  - An empty mask gives `done_valid_o` in cycle 1 and no bus activity.
- **Timeout:** a stalled write holds `reg_valid_o` for exactly `TimeoutCycles` cycles, then moves on to the next hart.
- **Reset mid-operation:** the command is abandoned, `reg_valid_o` drops in the cycle after `rst_i` is sampled high, and no `done_valid_o` pulse is emitted. Targets are not rolled back.
- **Request stability:** `reg_valid_o` never deasserts without `reg_ready_i` or a timeout.

## Test plan

- **All harts, no stall:** `NrHarts=5`, mask 5'b10101, set=1, ready tied high -> writes to 0x0, 0x8, 0x10 with wdata 1 in cycles 1–3; `done_valid_o` in cycle 4 with errmask 0; `cmd_ready_o` high in cycle 5.
- **Stalled bus:** mask 5'b00011, set=0, ready low for 3 cycles per write -> each address held 4 cycles with wdata 0; done with errmask 0.
- **Timeout:** `TimeoutCycles=16`, mask 5'b00100, ready never asserted -> `reg_valid_o` high for 16 cycles at 0x8; done with errmask 5'b00100 and `done_err_o=1`.
- **Bus error:** mask 5'b11111, `reg_error_i=1` only on the hart-3 write -> errmask 5'b01000; all five writes still issued.
- **Edge cases:**
  - Empty mask -> done pulse in cycle 1, errmask 0, no `reg_valid_o`.
  - A new command presented during WRITE -> not accepted until the cycle after DONE.
  - `rst_i` asserted during the second write of mask 5'b00111 -> outputs return to reset values, no done pulse, `cmd_ready_o=1` afterward.
